bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//   Parallel-in/serial-out shifter: accepts a C_DATA_WIDTH word over a valid/ready handshake
//   and emits it one bit per enabled clock on dout, tagged with dout_valid/dout_last.
//   Transmit-side counterpart of the single-bit SRL delay lines in the matcher datapath:
//   feeds serial bit streams (e.g. descriptor bits) into bit-wide delay/compare chains.
//   Clock-enable stalls the whole block, matching the ce convention of the delay lines.
// PARAMETERS
//   C_DATA_WIDTH  8  word width in bits; legal range >= 2
//   C_MSB_FIRST   1  1: bit [W-1] sent first; 0: bit [0] sent first
// PORTS
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   ce          in   1  clock enable; 0 freezes all state (no load, no shift)
//   din         in   W  parallel word to serialise
//   din_valid   in   1  din holds a word to transfer
//   din_ready   out  1  block accepts din this cycle (combinational)
//   dout        out  1  current serial bit (registered)
//   dout_valid  out  1  dout carries a bit of an accepted word (registered)
//   dout_last   out  1  dout is the final bit of the word (registered)
//   busy        out  1  word in flight (state == SHIFT)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, shift_reg=0, cnt=0, dout=0, dout_valid=0,
//     dout_last=0, busy=0; din_ready=0 while in reset. Reset mid-word drops the word; no
//     further bits of it appear after reset releases.
//   State: IDLE (no word), SHIFT (bit cnt of word on dout). cnt width clog2(W), range 0..W-1.
//   din_ready = ce & (state==IDLE | (state==SHIFT & cnt==W-1)).
//   Accept = din_valid & din_ready. On accept: shift_reg<=din (bit-reversed if C_MSB_FIRST=0
//     so the shift direction is fixed), cnt<=0, state<=SHIFT. First bit on dout the cycle after
//     accept (latency 1 clk from accept to first dout_valid).
//   SHIFT, ce=1, cnt<W-1: shift_reg shifts toward MSB (zero fill), cnt<=cnt+1.
//   SHIFT, ce=1, cnt==W-1: if accept -> load new word, cnt<=0, stay SHIFT (back-to-back, zero
//     bubble); else state<=IDLE, dout_valid<=0.
//   ce=0: every register holds; dout/dout_valid/dout_last stay stable; din_ready=0.
//   dout = shift_reg[W-1]; dout_valid = (state==SHIFT); dout_last = (state==SHIFT & cnt==W-1).
//   Each word produces exactly W enabled cycles with dout_valid=1; dout_last asserted on
//     exactly one of them. dout_valid counts enabled cycles only; a stalled bit may be held
//     on dout for many clocks and is one bit, not several.
//   din_valid while not ready is ignored (no latching); upstream must hold din stable until
//     accepted.
//   IDLE: dout=0 (shift_reg zero-filled by the completed word).
// TESTING
//   1. W=8, MSB_FIRST=1, ce=1, din=8'hA5 pulse -> dout 1,0,1,0,0,1,0,1 on cycles 1..8 after
//      accept; dout_last only on cycle 8; dout_valid=0 on cycle 9.
//   2. MSB_FIRST=0, din=8'h01 -> dout 1 then seven 0s; dout_last on the 8th bit.
//   3. Back-to-back: din_valid held high with 8'hFF then 8'h00 -> 16 consecutive dout_valid
//      cycles (8 ones, 8 zeros), din_ready high only at accept 0 and at cnt==7.
//   4. ce toggled 1,0,0,1,... during 8'hC3 -> bit sequence unchanged (1,1,0,0,0,0,1,1); outputs
//      frozen during ce=0; din_ready=0 whenever ce=0.
//   5. rst_n pulsed low at bit 3 of 8'hF0 -> dout/dout_valid/dout_last/busy go 0 immediately
//      (async); after release din_ready=ce and no residual bits are emitted.
//   6. din_valid asserted while busy and cnt<W-1 -> word not taken; accepted only at cnt==W-1.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and clock enable.
// Emits one bit per enabled clock, tagging the final bit of each word.
module bit_serializer #(
  parameter int C_DATA_WIDTH = 8,
  parameter bit C_MSB_FIRST  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [C_DATA_WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic                    dout,
  output logic                    dout_valid,
  output logic                    dout_last,
  output logic                    busy
);

  localparam int W  = C_DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  shift_q;
  logic [W-1:0]  shift_d;
  logic [W-1:0]  din_ord;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_end;
  logic          accept;

  // Shift direction is always toward the MSB; LSB-first just reverses on load.
  always_comb begin
    din_ord = '0;
    for (int i = 0; i < W; i++) begin
      din_ord[i] = C_MSB_FIRST ? din[i] : din[W-1-i];
    end
  end

  assign at_end    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign din_ready = rst_n & ce & ((state_q == IDLE) | at_end);
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (ce) begin
      if (accept) begin
        state_d = SHIFT;
        shift_d = din_ord;
        cnt_d   = '0;
      end else if (state_q == SHIFT) begin
        // Final shift clears the register so IDLE drives zero.
        shift_d = {shift_q[W-2:0], 1'b0};
        if (at_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout       = shift_q[W-1];
  assign dout_valid = (state_q == SHIFT);
  assign dout_last  = at_end;
  assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB- and LSB-first instances,
// back-to-back loads, clock-enable stalls, async reset and busy refusal.
module tb_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       dout;
  logic       dout_valid;
  logic       dout_last;
  logic       busy;

  logic [7:0] din1;
  logic       din_valid1;
  logic       din_ready1;
  logic       dout1;
  logic       dout_valid1;
  logic       dout_last1;
  logic       busy1;

  int checks;
  int errors;

  bit_serializer #(
    .C_DATA_WIDTH(8),
    .C_MSB_FIRST (1'b1)
  ) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .busy      (busy)
  );

  bit_serializer #(
    .C_DATA_WIDTH(8),
    .C_MSB_FIRST (1'b0)
  ) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .din       (din1),
    .din_valid (din_valid1),
    .din_ready (din_ready1),
    .dout      (dout1),
    .dout_valid(dout_valid1),
    .dout_last (dout_last1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_n      = 1'b0;
    ce         = 1'b1;
    din        = 8'h00;
    din_valid  = 1'b0;
    din1       = 8'h00;
    din_valid1 = 1'b0;
    step();
    got = {dout, dout_valid, dout_last, busy};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=0000", got);
    end
    checks++;
    if (din_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0", din_ready);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got=%b exp=1", din_ready);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    logic [3:0] got;
    logic [3:0] exp;
    w = 8'hA5;
    din = w;
    din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL msb_ready got=%b exp=1", din_ready);
    end
    step();
    din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got = {dout, dout_valid, dout_last, busy};
      exp = {w[7-k], 1'b1, (k == 7), 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL msb_bit%0d got=%b exp=%b", k, got, exp);
      end
      step();
    end
    got = {dout, dout_valid, dout_last, busy};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL msb_after got=%b exp=0000", got);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    logic [2:0] got;
    logic [2:0] exp;
    w = 8'h01;
    din1 = w;
    din_valid1 = 1'b1;
    step();
    din_valid1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got = {dout1, dout_valid1, dout_last1};
      exp = {w[k], 1'b1, (k == 7)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lsb_bit%0d got=%b exp=%b", k, got, exp);
      end
      step();
    end
    checks++;
    if (dout_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_after valid got=%b exp=0", dout_valid1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic [3:0] got;
    logic [3:0] exp;
    din = 8'hFF;
    din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready0 got=%b exp=1", din_ready);
    end
    step();
    din = 8'h00;
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 8'hFF : 8'h00;
      for (int k = 0; k < 8; k++) begin
        got = {dout, dout_valid, dout_last, din_ready};
        exp = {w[7-k], 1'b1, (k == 7), (k == 7)};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b_w%0d_bit%0d got=%b exp=%b", n, k, got, exp);
        end
        step();
        if (n == 0 && k == 7) din_valid = 1'b0;
      end
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after valid got=%b exp=0", dout_valid);
    end
  endtask

  task automatic test_ce_stall();
    logic [7:0] w;
    logic [2:0] got;
    logic [2:0] exp;
    int stall;
    w = 8'hC3;
    din = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      stall = k % 3;
      for (int s = 0; s <= stall; s++) begin
        got = {dout, dout_valid, dout_last};
        exp = {w[7-k], 1'b1, (k == 7)};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL ce_bit%0d_s%0d got=%b exp=%b", k, s, got, exp);
        end
        if (s < stall) begin
          ce = 1'b0;
          #1;
          checks++;
          if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL ce_ready got=%b exp=0", din_ready);
          end
        end else begin
          ce = 1'b1;
        end
        step();
      end
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ce_after valid got=%b exp=0", dout_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    din = 8'hF0;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    step();
    got = {dout, dout_valid, dout_last, busy};
    checks++;
    if (got !== 4'b1101) begin
      errors++;
      $display("FAIL rst_pre got=%b exp=1101", got);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {dout, dout_valid, dout_last, busy};
    checks++;
    if (got !== 4'b0000 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got=%b rdy=%b exp=0000 rdy=0",
               got, din_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got=%b exp=1", din_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (dout_valid !== 1'b0 || dout !== 1'b0) begin
        errors++;
        $display("FAIL rst_residual cyc%0d got=%b%b exp=00",
                 i, dout, dout_valid);
      end
    end
  endtask

  task automatic test_busy_refuse();
    logic [7:0] w;
    logic [7:0] w2;
    logic [2:0] got;
    logic [2:0] exp;
    w  = 8'hAA;
    w2 = 8'h36;
    din = w;
    din_valid = 1'b1;
    step();
    din = w2;
    for (int k = 0; k < 8; k++) begin
      got = {dout, dout_valid, din_ready};
      exp = {w[7-k], 1'b1, (k == 7)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL busy_bit%0d got=%b exp=%b", k, got, exp);
      end
      step();
    end
    din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got = {dout, dout_valid, dout_last};
      exp = {w2[7-k], 1'b1, (k == 7)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL busy_next_bit%0d got=%b exp=%b", k, got, exp);
      end
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_ce_stall();
    test_async_reset();
    test_busy_refuse();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
